dz_tx_scanner: RTL and testbench

- Transmit line scanner for the DZ11 multiplexer.
- Round-robin scans the 8 transmit lines and selects the next line that is both enabled in TCR and has an empty UART transmitter.
- Presents the selected line as CSR[TLINE] and raises CSR[TRDY], then holds until software writes TDR (low byte) or the line becomes ineligible.
- Sits between the CSR/TCR registers, the TDR write decode and the eight UART transmitters. It sequences which line TDR loads go to.

---
 rtl/dz_tx_scanner.sv | 139 +++++++++++++
 tb/tb_dz_tx_scanner.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dz_tx_scanner.sv
// DZ11 transmit line scanner: round-robin search of the 8 transmit lines for one
// that is enabled in TCR with an empty UART, then holds it as CSR[TLINE]/CSR[TRDY].
module dz_tx_scanner #(
  parameter int SCANDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       csrMSE,
  input  logic [7:0] tcrLIN,
  input  logic [7:0] uartTXEMPTY,
  input  logic       tdrWRITE,
  input  logic       devLOBYTE,
  output logic       csrTRDY,
  output logic [2:0] csrTLINE,
  output logic       trdySET
);

  localparam int DIVW = (SCANDIV > 1) ? $clog2(SCANDIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCANDIV - 1);
  localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);
  localparam logic [DIVW-1:0] DIV_ZERO = DIVW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    READY = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      ptr_r, ptr_s;
  logic [DIVW-1:0] div_r, div_s;
  logic            hold_r, hold_s;
  logic            trdy_r, trdy_s;
  logic [2:0]      tline_r, tline_s;
  logic            set_r, set_s;
  logic            elig_s;

  assign elig_s = csrMSE & tcrLIN[ptr_r] & uartTXEMPTY[ptr_r];

  // Next-state and next-output decode; dropping MSE overrides every state.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    div_s   = div_r;
    hold_s  = hold_r;
    trdy_s  = trdy_r;
    tline_s = tline_r;
    set_s   = 1'b0;
    if (!csrMSE) begin
      state_s = IDLE;
      ptr_s   = 3'd0;
      div_s   = DIV_ZERO;
      hold_s  = 1'b0;
      trdy_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = SCAN;
          div_s   = DIV_ZERO;
        end
        SCAN: begin
          if (div_r == DIV_LAST) begin
            div_s = DIV_ZERO;
            if (elig_s) begin
              tline_s = ptr_r;
              trdy_s  = 1'b1;
              set_s   = 1'b1;
              state_s = READY;
            end else begin
              ptr_s = ptr_r + 3'd1;
            end
          end else begin
            div_s = div_r + DIV_ONE;
          end
        end
        READY: begin
          // A load beats a simultaneous TCR withdrawal.
          if (tdrWRITE && devLOBYTE) begin
            trdy_s  = 1'b0;
            ptr_s   = tline_r + 3'd1;
            hold_s  = 1'b0;
            state_s = HOLD;
          end else if (!tcrLIN[tline_r]) begin
            trdy_s  = 1'b0;
            ptr_s   = tline_r + 3'd1;
            div_s   = DIV_ZERO;
            state_s = SCAN;
          end else begin
            state_s = READY;
          end
        end
        HOLD: begin
          // Two cycles let the loaded UART drop txempty before it is rescanned.
          if (hold_r) begin
            hold_s  = 1'b0;
            div_s   = DIV_ZERO;
            state_s = SCAN;
          end else begin
            hold_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
          ptr_s   = 3'd0;
          div_s   = DIV_ZERO;
          hold_s  = 1'b0;
          trdy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      div_r   <= DIV_ZERO;
      hold_r  <= 1'b0;
      trdy_r  <= 1'b0;
      tline_r <= 3'd0;
      set_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      div_r   <= div_s;
      hold_r  <= hold_s;
      trdy_r  <= trdy_s;
      tline_r <= tline_s;
      set_r   <= set_s;
    end
  end

  assign csrTRDY  = trdy_r;
  assign csrTLINE = tline_r;
  assign trdySET  = set_r;

endmodule

// File: tb/tb_dz_tx_scanner.sv
// Self-checking bench for dz_tx_scanner: directed scenarios plus randomized traffic
// compared against a next-grant/latency model; SCANDIV=1 and 256 copies for the sweep.
module tb_dz_tx_scanner;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mse = 1'b0;
  logic [7:0] tcr = 8'h00;
  logic [7:0] empty = 8'hFF;
  logic       wr = 1'b0;
  logic       lo = 1'b0;

  logic       trdy4, set4, trdy1, set1, trdy256, set256;
  logic [2:0] tline4, tline1, tline256;

  int n_cmp = 0;
  int n_bad = 0;
  int cur = 0;

  always #5 clk = ~clk;

  dz_tx_scanner #(.SCANDIV(SD)) dut (
    .clk(clk), .rst(rst), .csrMSE(mse), .tcrLIN(tcr), .uartTXEMPTY(empty),
    .tdrWRITE(wr), .devLOBYTE(lo), .csrTRDY(trdy4), .csrTLINE(tline4), .trdySET(set4));

  dz_tx_scanner #(.SCANDIV(1)) dut1 (
    .clk(clk), .rst(rst), .csrMSE(mse), .tcrLIN(tcr), .uartTXEMPTY(empty),
    .tdrWRITE(wr), .devLOBYTE(lo), .csrTRDY(trdy1), .csrTLINE(tline1), .trdySET(set1));

  dz_tx_scanner #(.SCANDIV(256)) dut256 (
    .clk(clk), .rst(rst), .csrMSE(mse), .tcrLIN(tcr), .uartTXEMPTY(empty),
    .tdrWRITE(wr), .devLOBYTE(lo), .csrTRDY(trdy256), .csrTLINE(tline256), .trdySET(set256));

  // Reference: first eligible line met when walking forward from start (mod 8).
  function automatic int model_line(input int start, input logic [7:0] elig);
    for (int d = 0; d < 8; d++)
      if (elig[(start + d) % 8]) return (start + d) % 8;
    return -1;
  endfunction

  // Waits for the SCANDIV=4 grant. base = cycles before scanning starts at 'start'.
  task automatic expect_grant(input string name, input int base, input int start,
                              input logic [7:0] elig, output int line);
    int k, exp_cyc, cnt, pulses;
    bit got;
    line = model_line(start, elig);
    k = ((line - start + 8) % 8) + 1;
    exp_cyc = base + k * SD;
    cnt = 0; pulses = 0; got = 1'b0;
    while (!got && cnt < exp_cyc + 40) begin
      @(negedge clk);
      cnt++;
      wr = 1'b0; lo = 1'b0;
      if (set4) pulses++;
      if (trdy4) got = 1'b1;
    end
    n_cmp++;
    if (!got || cnt != exp_cyc) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles (seen=%0d), expected %0d", name, cnt, got, exp_cyc);
    end
    n_cmp++;
    if (int'(tline4) != line) begin
      n_bad++;
      $display("FAIL %s tline: got %0d, expected %0d", name, tline4, line);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL %s trdyset_count: got %0d, expected 1", name, pulses);
    end
    @(negedge clk);
    n_cmp++;
    if (set4 !== 1'b0 || trdy4 !== 1'b1) begin
      n_bad++;
      $display("FAIL %s after_grant: trdy=%b set=%b, expected trdy=1 set=0", name, trdy4, set4);
    end
  endtask

  task automatic start_from_reset();
    @(negedge clk);
    rst = 1'b1; mse = 1'b0; wr = 1'b0; lo = 1'b0;
    @(negedge clk);
    rst = 1'b0; mse = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mse = 1'b1; tcr = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (trdy4 !== 1'b0 || tline4 !== 3'd0 || set4 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: trdy=%b tline=%0d set=%b, expected 0/0/0", trdy4, tline4, set4);
    end
  endtask

  task automatic test_first_grant();
    tcr = 8'h20; empty = 8'hFF;
    start_from_reset();
    expect_grant("first_grant", 1, 0, 8'h20, cur);
  endtask

  task automatic test_load_wrap();
    @(negedge clk);
    tcr = 8'h21; wr = 1'b1; lo = 1'b1;
    expect_grant("load_wrap", 3, (cur + 1) % 8, 8'h21, cur);
  endtask

  task automatic test_round_robin();
    int prev;
    tcr = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      prev = cur;
      @(negedge clk);
      wr = 1'b1; lo = 1'b1;
      expect_grant("round_robin", 3, (prev + 1) % 8, 8'hFF, cur);
      n_cmp++;
      if (cur != (prev + 1) % 8) begin
        n_bad++;
        $display("FAIL round_robin_order: got %0d, expected %0d", cur, (prev + 1) % 8);
      end
    end
  endtask

  task automatic test_withdraw();
    tcr = 8'h18;
    start_from_reset();
    expect_grant("withdraw_setup", 1, 0, 8'h18, cur);
    @(negedge clk);
    tcr = 8'h10;
    expect_grant("withdraw", 1, 4, 8'h10, cur);
    @(negedge clk);
    tcr = 8'h01; wr = 1'b1; lo = 1'b1;
    expect_grant("load_wins", 3, 5, 8'h01, cur);
  endtask

  task automatic test_edges();
    @(negedge clk);
    tcr = 8'h04; wr = 1'b1; lo = 1'b1;
    expect_grant("edge_setup", 3, 1, 8'h04, cur);
    @(negedge clk);
    wr = 1'b1; lo = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr = 1'b0;
      empty = 8'h00;
      n_cmp++;
      if (trdy4 !== 1'b1 || set4 !== 1'b0 || tline4 !== 3'd2) begin
        n_bad++;
        $display("FAIL hibyte_or_empty_drop: trdy=%b set=%b tline=%0d, expected 1/0/2", trdy4, set4, tline4);
      end
    end
    empty = 8'hFF;
    @(negedge clk);
    mse = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (trdy4 !== 1'b0 || tline4 !== 3'd2) begin
      n_bad++;
      $display("FAIL mse_clear: trdy=%b tline=%0d, expected 0/2", trdy4, tline4);
    end
    tcr = 8'h06; mse = 1'b1;
    expect_grant("mse_restart", 1, 0, 8'h06, cur);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (trdy4 !== 1'b0 || tline4 !== 3'd0 || set4 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_ready: trdy=%b tline=%0d set=%b, expected 0/0/0", trdy4, tline4, set4);
    end
    tcr = 8'h08;
    start_from_reset();
    expect_grant("reset_scan_setup", 1, 0, 8'h08, cur);
    @(negedge clk);
    tcr = 8'h80;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (trdy4 !== 1'b0 || tline4 !== 3'd0 || set4 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_scan: trdy=%b tline=%0d set=%b, expected 0/0/0", trdy4, tline4, set4);
    end
  endtask

  task automatic pick_random(input int avoid);
    do begin
      tcr = 8'($urandom);
      empty = 8'($urandom);
      if (avoid >= 0) tcr[avoid] = 1'b0;
    end while ((tcr & empty) == 8'h00);
  endtask

  task automatic test_random();
    int act;
    pick_random(-1);
    start_from_reset();
    expect_grant("rand_start", 1, 0, tcr & empty, cur);
    for (int it = 0; it < 40; it++) begin
      act = int'($urandom_range(0, 3));
      @(negedge clk);
      case (act)
        0: begin
          pick_random(-1);
          wr = 1'b1; lo = 1'b1;
          expect_grant("rand_load", 3, (cur + 1) % 8, tcr & empty, cur);
        end
        1: begin
          pick_random(cur);
          expect_grant("rand_withdraw", 1, (cur + 1) % 8, tcr & empty, cur);
        end
        2: begin
          wr = 1'b1; lo = 1'b0;
          empty = 8'($urandom);
          @(negedge clk);
          wr = 1'b0;
          n_cmp++;
          if (trdy4 !== 1'b1 || int'(tline4) != cur) begin
            n_bad++;
            $display("FAIL rand_hold: trdy=%b tline=%0d, expected 1/%0d", trdy4, tline4, cur);
          end
        end
        default: begin
          mse = 1'b0;
          @(negedge clk);
          n_cmp++;
          if (trdy4 !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_mse_off: trdy=%b, expected 0", trdy4);
          end
          pick_random(-1);
          mse = 1'b1;
          expect_grant("rand_mse_on", 1, 0, tcr & empty, cur);
        end
      endcase
    end
  endtask

  task automatic test_scandiv_sweep();
    int c1, c4, c256, cnt, line, e1, e4, e256;
    for (int m = 0; m < 2; m++) begin
      line = (m == 0) ? 7 : 0;
      tcr = 8'h00;
      tcr[line] = 1'b1;
      empty = 8'hFF;
      start_from_reset();
      c1 = -1; c4 = -1; c256 = -1; cnt = 0;
      while (c256 < 0 && cnt < 1 + 8 * 256 + 20) begin
        @(negedge clk);
        cnt++;
        if (trdy1 && c1 < 0) c1 = cnt;
        if (trdy4 && c4 < 0) c4 = cnt;
        if (trdy256 && c256 < 0) c256 = cnt;
      end
      e1 = 1 + (line + 1) * 1;
      e4 = 1 + (line + 1) * 4;
      e256 = 1 + (line + 1) * 256;
      n_cmp++;
      if (c1 != e1 || int'(tline1) != line) begin
        n_bad++;
        $display("FAIL sweep_div1: rise=%0d line=%0d, expected %0d/%0d", c1, tline1, e1, line);
      end
      n_cmp++;
      if (c4 != e4 || int'(tline4) != line) begin
        n_bad++;
        $display("FAIL sweep_div4: rise=%0d line=%0d, expected %0d/%0d", c4, tline4, e4, line);
      end
      n_cmp++;
      if (c256 != e256 || int'(tline256) != line) begin
        n_bad++;
        $display("FAIL sweep_div256: rise=%0d line=%0d, expected %0d/%0d", c256, tline256, e256, line);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_load_wrap();
    test_round_robin();
    test_withdraw();
    test_edges();
    test_reset_mid();
    test_random();
    test_scandiv_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
